seg_pwm_monitor: RTL and testbench

//  Receive-side monitor for the 8-line PWM-faded segment chaser bus. Samples the raw segment

---
 rtl/seg_pwm_monitor.sv | 154 +++++++++++++++
 tb/tb_seg_pwm_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_pwm_monitor.sv
// Receive-side monitor for the 8-line PWM segment chaser: per-line duty per frame,
// brightest-line report and chase position/direction tracking around the 8-step ring.
module seg_pwm_monitor #(
  parameter int PWM_BITS    = 5,
  parameter int ACTIVE_LOW  = 1,
  parameter int MIN_DUTY    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          seg_in,
  input  logic [2:0]          rd_sel,
  output logic [PWM_BITS:0]   rd_duty,
  output logic                frame_valid,
  output logic [2:0]          bright_idx,
  output logic                bright_ok,
  output logic [2:0]          pos,
  output logic                step_fwd,
  output logic                step_rev,
  output logic                lost
);
  localparam int DW = PWM_BITS + 1;
  localparam logic [7:0] POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DUTY);

  logic [7:0]          sync_q [SYNC_STAGES];
  logic [7:0]          lit;
  logic [PWM_BITS-1:0] fc;
  logic                frame_end;
  logic [DW-1:0]       acc [8];
  logic [DW-1:0]       duty [8];
  logic [DW-1:0]       final_d [8];
  logic [DW-1:0]       max_d;
  logic [2:0]          max_idx;
  logic                max_ok;
  logic [2:0]          prev_idx;
  logic [2:0]          pos_nxt;
  logic                fwd_nxt;
  logic                rev_nxt;
  logic                lost_nxt;

  function automatic logic [2:0] ring_at(input logic [2:0] p);
    case (p)
      3'd0: ring_at = 3'd0;
      3'd1: ring_at = 3'd1;
      3'd2: ring_at = 3'd6;
      3'd3: ring_at = 3'd4;
      3'd4: ring_at = 3'd3;
      3'd5: ring_at = 3'd2;
      3'd6: ring_at = 3'd6;
      default: ring_at = 3'd5;
    endcase
  endfunction

  // Segment 6 sits at ring positions 2 and 6; a resync lands on the lower one.
  function automatic logic [2:0] ring_first(input logic [2:0] b);
    case (b)
      3'd0: ring_first = 3'd0;
      3'd1: ring_first = 3'd1;
      3'd6: ring_first = 3'd2;
      3'd4: ring_first = 3'd3;
      3'd3: ring_first = 3'd4;
      3'd2: ring_first = 3'd5;
      3'd5: ring_first = 3'd7;
      default: ring_first = 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= seg_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign lit       = sync_q[SYNC_STAGES-1] ^ POL;
  assign frame_end = &fc;

  // Final duty includes this cycle's sample so the last cycle of a frame is never lost.
  always_comb begin
    max_d   = '0;
    max_idx = '0;
    for (int i = 0; i < 8; i++) final_d[i] = acc[i] + {{PWM_BITS{1'b0}}, lit[i]};
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || final_d[i] > max_d) begin
        max_d   = final_d[i];
        max_idx = 3'(i);
      end
    end
    max_ok = (max_d >= MIN_D);
  end

  always_comb begin
    pos_nxt  = pos;
    fwd_nxt  = 1'b0;
    rev_nxt  = 1'b0;
    lost_nxt = 1'b0;
    if (max_ok && max_idx != prev_idx) begin
      if (max_idx == ring_at(pos + 3'd1)) begin
        pos_nxt = pos + 3'd1;
        fwd_nxt = 1'b1;
      end else if (max_idx == ring_at(pos - 3'd1)) begin
        pos_nxt = pos - 3'd1;
        rev_nxt = 1'b1;
      end else begin
        lost_nxt = 1'b1;
        if (max_idx != 3'd7) pos_nxt = ring_first(max_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc          <= '0;
      rd_duty     <= '0;
      frame_valid <= 1'b0;
      bright_idx  <= '0;
      bright_ok   <= 1'b0;
      pos         <= '0;
      prev_idx    <= '0;
      step_fwd    <= 1'b0;
      step_rev    <= 1'b0;
      lost        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc[i]  <= '0;
        duty[i] <= '0;
      end
    end else begin
      fc          <= fc + 1'b1;
      rd_duty     <= duty[rd_sel];
      frame_valid <= frame_end;
      step_fwd    <= 1'b0;
      step_rev    <= 1'b0;
      lost        <= 1'b0;
      if (frame_end) begin
        for (int i = 0; i < 8; i++) begin
          duty[i] <= final_d[i];
          acc[i]  <= '0;
        end
        bright_idx <= max_idx;
        bright_ok  <= max_ok;
        pos        <= pos_nxt;
        step_fwd   <= fwd_nxt;
        step_rev   <= rev_nxt;
        lost       <= lost_nxt;
        if (max_ok) prev_idx <= max_idx;
      end else begin
        for (int i = 0; i < 8; i++) acc[i] <= final_d[i];
      end
    end
  end
endmodule

// File: tb/tb_seg_pwm_monitor.sv
// Directed frames on the segment bus; per-frame expectations queued at drive time and
// checked when frame_valid pulses.
module tb_seg_pwm_monitor;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [2:0] rd_sel;
  logic [5:0] rd_duty;
  logic       frame_valid;
  logic [2:0] bright_idx;
  logic       bright_ok;
  logic [2:0] pos;
  logic       step_fwd;
  logic       step_rev;
  logic       lost;

  always #5 clk = ~clk;

  seg_pwm_monitor dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .rd_sel(rd_sel), .rd_duty(rd_duty),
    .frame_valid(frame_valid), .bright_idx(bright_idx), .bright_ok(bright_ok), .pos(pos),
    .step_fwd(step_fwd), .step_rev(step_rev), .lost(lost)
  );

  typedef struct packed {
    logic [7:0][5:0] duty;
    logic [2:0]      idx;
    logic            ok;
    logic [2:0]      pos;
    logic            fwd;
    logic            rev;
    logic            lost;
  } exp_t;

  exp_t            q[$];
  int              n_chk = 0;
  int              n_err = 0;
  logic [4:0]      ph;
  int              ring_t [8] = '{0, 1, 6, 4, 3, 2, 6, 5};
  int              fwd_seq [8] = '{1, 6, 4, 3, 2, 6, 5, 0};
  int              rev_seq [8] = '{0, 5, 6, 2, 3, 4, 6, 1};
  int              pos_m = 0;
  int              prev_m = 0;
  exp_t            e;
  logic [7:0][5:0] cur_tbl = '0;
  logic            pend = 1'b0;
  int              idle = 0;

  // Frame phase reference: the frame's last cycle is ph == 31.
  always @(posedge clk) ph <= reset ? 5'd0 : ph + 5'd1;

  // Frame model: lines in la lit for the first n cycles, lines in lb for the rest.
  task automatic push_frame(input logic [7:0] la, input int n, input logic [7:0] lb);
    int   d [8];
    int   b;
    exp_t x;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      d[i] = (la[i] ? n : 0) + (lb[i] ? 32 - n : 0);
      x.duty[i] = 6'(d[i]);
    end
    b = 0;
    for (int i = 1; i < 8; i++) if (d[i] > d[b]) b = i;
    x.idx = 3'(b);
    x.ok  = (d[b] >= 16);
    if (x.ok && b != prev_m) begin
      if (b == ring_t[(pos_m + 1) % 8]) begin
        pos_m = (pos_m + 1) % 8;
        x.fwd = 1'b1;
      end else if (b == ring_t[(pos_m + 7) % 8]) begin
        pos_m = (pos_m + 7) % 8;
        x.rev = 1'b1;
      end else begin
        x.lost = 1'b1;
        if (b != 7) for (int p = 7; p >= 0; p--) if (ring_t[p] == b) pos_m = p;
      end
    end
    if (x.ok) prev_m = b;
    x.pos = 3'(pos_m);
    q.push_back(x);
  endtask

  // Inputs changed at ph 30 reach the accumulators exactly at the next frame start.
  task automatic frame(input logic [7:0] la, input int n, input logic [7:0] lb, input logic [2:0] sel);
    do @(negedge clk); while (ph != 5'd30);
    seg_in = ~la;
    rd_sel = sel;
    push_frame(la, n, lb);
    if (n < 32) begin
      do @(negedge clk); while (ph != 5'(n - 2));
      seg_in = ~lb;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (reset) begin
      n_chk++;
      assert ({rd_duty, frame_valid, bright_idx, bright_ok, pos, step_fwd, step_rev, lost} === '0)
      else begin
        n_err++;
        $error("FAIL reset_state got %0h exp 0",
               {rd_duty, frame_valid, bright_idx, bright_ok, pos, step_fwd, step_rev, lost});
      end
      q.delete();
      pend = 1'b0;
      cur_tbl = '0;
      idle = 0;
    end else begin
      if (pend) begin
        n_chk++;
        assert (rd_duty === cur_tbl[rd_sel])
        else begin n_err++; $error("FAIL rd_duty_new got %0d exp %0d", rd_duty, cur_tbl[rd_sel]); end
        pend = 1'b0;
      end
      if (frame_valid) begin
        idle = 0;
        n_chk++;
        assert (q.size() != 0)
        else begin n_err++; $error("FAIL unexpected_frame got frame_valid=1 exp 0"); end
        if (q.size() != 0) begin
          e = q.pop_front();
          n_chk++;
          assert ({bright_idx, bright_ok, pos, step_fwd, step_rev, lost} === {e.idx, e.ok, e.pos, e.fwd, e.rev, e.lost})
          else begin
            n_err++;
            $error("FAIL frame_result got idx=%0d ok=%0d pos=%0d fwd/rev/lost=%b%b%b exp idx=%0d ok=%0d pos=%0d fwd/rev/lost=%b%b%b",
                   bright_idx, bright_ok, pos, step_fwd, step_rev, lost, e.idx, e.ok, e.pos, e.fwd, e.rev, e.lost);
          end
          n_chk++;
          assert (rd_duty === cur_tbl[rd_sel])
          else begin n_err++; $error("FAIL rd_duty_old got %0d exp %0d", rd_duty, cur_tbl[rd_sel]); end
          cur_tbl = e.duty;
          pend = 1'b1;
        end
        n_chk++;
        assert (ph === 5'd0)
        else begin n_err++; $error("FAIL frame_phase got %0d exp 0", ph); end
      end else begin
        idle++;
        n_chk++;
        assert ({step_fwd, step_rev, lost} === 3'b000)
        else begin n_err++; $error("FAIL stray_pulse got %b exp 000", {step_fwd, step_rev, lost}); end
        if (idle > 40) begin
          n_chk++;
          assert (q.size() == 0)
          else begin n_err++; $error("FAIL frame_timeout got %0d pending exp 0", q.size()); end
          idle = 0;
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    seg_in = 8'hFF;
    rd_sel = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Synchroniser resets to 0, which reads as all-lit for the first two cycles.
    push_frame(8'hFF, 2, 8'h00);

    frame(8'h00, 32, 8'h00, 3'd3);
    frame(8'h00, 32, 8'h00, 3'd5);

    frame(8'h01, 32, 8'h00, 3'd0);

    foreach (fwd_seq[k]) frame(8'(1 << fwd_seq[k]), 32, 8'h00, 3'(fwd_seq[k]));

    foreach (rev_seq[k]) frame(8'(1 << rev_seq[k]), 32, 8'h00, 3'(rev_seq[k]));

    frame(8'h18, 20, 8'h00, 3'd3);
    frame(8'h80, 32, 8'h00, 3'd7);

    frame(8'h02, 32, 8'h00, 3'd1);
    do @(negedge clk); while (ph != 5'd17);
    reset = 1'b1;
    pos_m = 0;
    prev_m = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_frame(8'hFF, 2, 8'h02);
    frame(8'h02, 32, 8'h00, 3'd1);

    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
